// File: rtl/phy_serializer.sv
// phy_serializer: parallel-to-serial shifter emitting OUT_BITS per channel per i_pclkx5 cycle, plus a TMDS clock channel.
// Optional PRBS7 test mode is compiled in only when PHY_SERIALIZER_PRBS_EN is defined.
module phy_serializer #(
    parameter int NUM_CH   = 3,
    parameter int WORD_W   = 10,
    parameter int OUT_BITS = 2,
    parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                         i_pclkx5,
    input  logic                         i_rstn,
    input  logic [NUM_CH*WORD_W-1:0]     i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_prbs_en,
    input  logic                         i_clr_underflow,
    output logic [NUM_CH*OUT_BITS-1:0]   o_tx,
    output logic [OUT_BITS-1:0]          o_clk_bits,
    output logic                         o_underflow
);
    localparam int DIV  = WORD_W / OUT_BITS;
    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0]   LAST_PHASE = PH_W'(DIV - 1);
    localparam logic [WORD_W-1:0] CLK_WORD   = {WORD_W{1'b1}} >> (WORD_W - WORD_W / 2);

    logic [PH_W-1:0]   phase_r;
    logic [PH_W-1:0]   phase_nxt_s;
    logic              ready_r;
    logic              started_r;
    logic              underflow_r;
    logic [WORD_W-1:0] data_sr_r [NUM_CH];
    logic [WORD_W-1:0] clk_sr_r;
    logic [WORD_W-1:0] load_word_s [NUM_CH];
    logic [WORD_W-1:0] prbs_word_s;
    logic              prbs_active_s;
    logic              load_slot_s;
    logic              accept_s;
    logic              uf_set_s;

    assign load_slot_s = (phase_r == LAST_PHASE);
    assign accept_s    = load_slot_s & i_valid & ~prbs_active_s;
    assign uf_set_s    = load_slot_s & ~i_valid & started_r & ~prbs_active_s;

`ifdef PHY_SERIALIZER_PRBS_EN
    localparam logic [6:0] PRBS_SEED = 7'h7F;
    logic [6:0] prbs_r;
    logic [6:0] prbs_nxt_s;

    // x^7+x^6+1, WORD_W steps at a time; word bit i is the i-th new bit (sent LSB first)
    function automatic logic [WORD_W+6:0] prbs7_advance(input logic [6:0] state);
        logic [6:0]        s;
        logic [WORD_W-1:0] w;
        logic              nb;
        s = state;
        w = '0;
        for (int i = 0; i < WORD_W; i++) begin
            nb   = s[6] ^ s[5];
            w[i] = nb;
            s    = {s[5:0], nb};
        end
        return {s, w};
    endfunction

    assign prbs_active_s = i_prbs_en;
    assign {prbs_nxt_s, prbs_word_s} = prbs7_advance(prbs_r);

    // PRBS generator advances one full word per test-mode load slot
    always_ff @(posedge i_pclkx5 or negedge i_rstn) begin
        if (!i_rstn) begin
            prbs_r <= PRBS_SEED;
        end else if (load_slot_s && prbs_active_s) begin
            prbs_r <= prbs_nxt_s;
        end else begin
            prbs_r <= prbs_r;
        end
    end
`else
    logic prbs_unused_s;
    assign prbs_unused_s = i_prbs_en;
    assign prbs_active_s = 1'b0;
    assign prbs_word_s   = '0;
`endif

    // Phase advance: wraps at the load slot
    always_comb begin
        phase_nxt_s = phase_r + PH_W'(1);
        if (load_slot_s) begin
            phase_nxt_s = '0;
        end else begin
            phase_nxt_s = phase_r + PH_W'(1);
        end
    end

    // Per-channel load word: test pattern, accepted data, or idle symbol
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            load_word_s[c] = IDLE_WORD;
            if (prbs_active_s) begin
                load_word_s[c] = prbs_word_s;
            end else if (i_valid) begin
                load_word_s[c] = i_data[c*WORD_W +: WORD_W];
            end else begin
                load_word_s[c] = IDLE_WORD;
            end
        end
    end

    // Phase counter and registered ready decode (high exactly while phase_r is the last phase)
    always_ff @(posedge i_pclkx5 or negedge i_rstn) begin
        if (!i_rstn) begin
            phase_r <= '0;
            ready_r <= 1'b0;
        end else begin
            phase_r <= phase_nxt_s;
            ready_r <= (phase_nxt_s == LAST_PHASE);
        end
    end

    // Data and clock shift registers share the load slot so they stay phase-aligned
    always_ff @(posedge i_pclkx5 or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_sr_r[c] <= '0;
            end
            clk_sr_r <= '0;
        end else if (load_slot_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_sr_r[c] <= load_word_s[c];
            end
            clk_sr_r <= CLK_WORD;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_sr_r[c] <= data_sr_r[c] >> OUT_BITS;
            end
            clk_sr_r <= clk_sr_r >> OUT_BITS;
        end
    end

    // Underflow is only meaningful once the stream has started; set beats clear
    always_ff @(posedge i_pclkx5 or negedge i_rstn) begin
        if (!i_rstn) begin
            started_r   <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            started_r <= started_r | accept_s;
            if (uf_set_s) begin
                underflow_r <= 1'b1;
            end else if (i_clr_underflow) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    // Serial bits come straight from the low end of each shift register
    always_comb begin
        o_tx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_tx[c*OUT_BITS +: OUT_BITS] = data_sr_r[c][OUT_BITS-1:0];
        end
    end

    assign o_clk_bits  = clk_sr_r[OUT_BITS-1:0];
    assign o_ready     = ready_r & ~prbs_active_s;
    assign o_underflow = underflow_r;

endmodule

// File: tb/tb_phy_serializer.sv
// Self-checking bench for phy_serializer (NUM_CH=3, WORD_W=10, OUT_BITS=2): symbol table plus scoreboard of serial beats.
module tb_phy_serializer;
    localparam int NUM_CH = 3;
    localparam int WORD_W = 10;
    localparam int OUT_BITS = 2;
    localparam int DIV = 5;

    typedef struct packed {
        logic [5:0] tx;
        logic [1:0] clkb;
    } beat_t;

    typedef struct {
        logic        valid;
        logic [29:0] data;
        logic        exp_uf;
    } vec_t;

    logic        tb_clk = 1'b0;
    logic        rstn = 1'b1;
    logic [29:0] drv_data = '0;
    logic        drv_valid = 1'b0;
    logic        drv_prbs = 1'b0;
    logic        drv_clr = 1'b0;
    logic        o_ready;
    logic [5:0]  o_tx;
    logic [1:0]  o_clk_bits;
    logic        o_underflow;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_phase = 0;
    beat_t exp_q[$];
    int prbs_hist[$];
    logic [9:0] idle_w = 10'b1101010100;
    logic [9:0] clk_w  = 10'b0000011111;
    vec_t vecs[4];

    phy_serializer #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .OUT_BITS(OUT_BITS), .IDLE_WORD(10'b1101010100)
    ) dut (
        .i_pclkx5(tb_clk),
        .i_rstn(rstn),
        .i_data(drv_data),
        .i_valid(drv_valid),
        .o_ready(o_ready),
        .i_prbs_en(drv_prbs),
        .i_clr_underflow(drv_clr),
        .o_tx(o_tx),
        .o_clk_bits(o_clk_bits),
        .o_underflow(o_underflow)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic prbs_mode();
`ifdef PHY_SERIALIZER_PRBS_EN
        return drv_prbs;
`else
        return 1'b0;
`endif
    endfunction

    // Reference PRBS7: each new bit is the xor of the bits 7 and 6 positions back
    function automatic logic [9:0] prbs_model_word();
        logic [9:0] w;
        int n;
        w = '0;
        for (int i = 0; i < WORD_W; i++) begin
            n = prbs_hist[prbs_hist.size()-7] ^ prbs_hist[prbs_hist.size()-6];
            w[i] = n[0];
            prbs_hist.push_back(n);
        end
        return w;
    endfunction

    task automatic step();
        logic       exp_ready;
        logic [9:0] w;
        logic [9:0] pw;
        beat_t      b;
        exp_ready = (m_phase == DIV-1) && !prbs_mode();
        check("ready", {31'd0, o_ready}, {31'd0, exp_ready});
        if (m_phase == DIV-1) begin
            pw = prbs_mode() ? prbs_model_word() : 10'd0;
            for (int p = 0; p < DIV; p++) begin
                b = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    w = prbs_mode() ? pw : (drv_valid ? drv_data[c*10 +: 10] : idle_w);
                    b.tx[c*2 +: 2] = w[p*2 +: 2];
                end
                b.clkb = clk_w[p*2 +: 2];
                exp_q.push_back(b);
            end
        end
        @(posedge tb_clk);
        m_phase = (m_phase == DIV-1) ? 0 : m_phase + 1;
        cyc++;
        @(negedge tb_clk);
        if (exp_q.size() > 0) b = exp_q.pop_front();
        else b = '0;
        check("tx", {26'd0, o_tx}, {26'd0, b.tx});
        check("clk_bits", {30'd0, o_clk_bits}, {30'd0, b.clkb});
    endtask

    // Asserts reset, checks outputs are cleared asynchronously, releases at a falling edge
    task automatic do_reset();
        drv_valid = 1'b0;
        drv_clr = 1'b0;
        drv_prbs = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_tx", {26'd0, o_tx}, 32'd0);
        check("rst_clk_bits", {30'd0, o_clk_bits}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_underflow", {31'd0, o_underflow}, 32'd0);
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        rstn = 1'b1;
        m_phase = 0;
        cyc = 0;
        exp_q.delete();
        prbs_hist.delete();
        repeat (7) prbs_hist.push_back(1);
    endtask

    initial begin
        logic [31:0] ready_mask;
        int ready_at;

        vecs[0] = '{valid: 1'b1, data: {10'h2AB, 10'h155, 10'h3A5}, exp_uf: 1'b0};
        vecs[1] = '{valid: 1'b1, data: {10'h0FF, 10'h300, 10'h001}, exp_uf: 1'b0};
        vecs[2] = '{valid: 1'b0, data: {10'h3FF, 10'h3FF, 10'h3FF}, exp_uf: 1'b1};
        vecs[3] = '{valid: 1'b1, data: {10'h123, 10'h000, 10'h3FF}, exp_uf: 1'b1};

        #2;
        do_reset();

        // Symbol table: each entry spans one full symbol period, loaded on its last cycle
        for (int v = 0; v < 4; v++) begin
            drv_valid = vecs[v].valid;
            drv_data  = vecs[v].data;
            repeat (DIV) step();
            check("underflow_table", {31'd0, o_underflow}, {31'd0, vecs[v].exp_uf});
        end

        // Clear pulse on a non-load edge, then set and clear on the same load edge
        drv_valid = 1'b0;
        drv_clr = 1'b1;
        step();
        drv_clr = 1'b0;
        check("underflow_cleared", {31'd0, o_underflow}, 32'd0);
        repeat (3) step();
        drv_clr = 1'b1;
        step();
        drv_clr = 1'b0;
        check("underflow_set_wins", {31'd0, o_underflow}, 32'd1);

        // Valid held high for 20 cycles from reset: loads at cycles 4, 9, 14, 19
        do_reset();
        drv_valid = 1'b1;
        drv_data = {10'h1C7, 10'h2D2, 10'h05A};
        ready_mask = '0;
        for (int i = 0; i < 20; i++) begin
            if (o_ready) ready_mask[i] = 1'b1;
            step();
        end
        check("ready_cycles", ready_mask, 32'h0008_4210);
        drv_valid = 1'b0;
        repeat (DIV) step();

        // Reset mid-symbol at phase 2, then first load slot four cycles after release
        do_reset();
        drv_valid = 1'b1;
        drv_data = {10'h2AB, 10'h155, 10'h3A5};
        repeat (DIV + 2) step();
        check("phase2_clk_bits", {30'd0, o_clk_bits}, 32'd1);
        do_reset();
        drv_valid = 1'b1;
        ready_at = -1;
        for (int i = 0; i < 10; i++) begin
            if (o_ready && ready_at < 0) ready_at = i;
            step();
        end
        check("first_ready_after_reset", ready_at, 32'd4);

        // Test-pattern request: PRBS path when compiled in, ordinary data otherwise
        do_reset();
        drv_prbs = 1'b1;
        drv_valid = 1'b1;
        drv_data = {10'h0F0, 10'h33C, 10'h2A5};
        repeat (4 * DIV) step();
        check("prbs_underflow", {31'd0, o_underflow}, 32'd0);
        drv_prbs = 1'b0;
        drv_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/phy_serializer.md
PHY_SERIALIZER -- requirements
Module: phy_serializer

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning the number of TMDS data channels.
REQ-002 SHALL have parameter WORD_W, default 10, meaning the parallel symbol width per channel.
REQ-003 SHALL have parameter OUT_BITS, default 2, meaning bits emitted per channel per clock; WORD_W SHALL be an integer multiple of OUT_BITS, and DIV = WORD_W/OUT_BITS.
REQ-004 SHALL have parameter IDLE_WORD, default 10'b1101010100, meaning the symbol sent when no data is available.
REQ-005 SHALL have one clock and one reset: i_pclkx5  in  1  serial-rate clock, the only clock; reset is asynchronous and active-low.
REQ-006 SHALL have port i_rstn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port i_data  in  NUM_CH*WORD_W  parallel symbols, channel k at [k*WORD_W +: WORD_W].
REQ-008 SHALL have port i_valid  in  1  i_data valid.
REQ-009 SHALL have port o_ready  out  1  symbol load slot; a transfer occurs when i_valid and o_ready are both high on a rising edge.
REQ-010 SHALL have port i_prbs_en  in  1  test-pattern request.
REQ-011 SHALL have port i_clr_underflow  in  1  clears o_underflow.
REQ-012 SHALL have port o_tx  out  NUM_CH*OUT_BITS  serial bits, channel k at [k*OUT_BITS +: OUT_BITS], to the output serdes/DDR cells.
REQ-013 SHALL have port o_clk_bits  out  OUT_BITS  TMDS clock-channel bits.
REQ-014 SHALL have port o_underflow  out  1  sticky flag for a missed symbol.

Function
REQ-015 SHALL maintain a phase counter counting 0..DIV-1, wrapping to 0; the load slot is phase == DIV-1.
REQ-016 SHALL drive o_ready high during exactly the cycles in which phase == DIV-1, and low in all other cycles.
REQ-017 SHALL, on the load-slot edge, load each channel shift register with its i_data slice if i_valid is high, else with IDLE_WORD.
REQ-018 SHALL, on every non-load edge, shift each register right by OUT_BITS.
REQ-019 SHALL drive o_tx from the registered low OUT_BITS of each shift register, so transmission is LSB first and a symbol accepted at edge E appears on o_tx in the cycle immediately after E and spans DIV cycles.
REQ-020 SHALL load the clock shift register at the same edge with a word whose low WORD_W/2 bits are 1 and whose high bits are 0, and shift it identically; the clock channel therefore stays phase-aligned with the data channels.
REQ-021 SHALL set an internal "started" flag at the first accepted transfer.
REQ-022 SHALL set o_underflow on a load slot with i_valid low, only once "started" is set.
REQ-023 SHALL clear o_underflow when i_clr_underflow is high; if a set and a clear occur on the same edge, set wins.
REQ-024 SHALL ignore i_valid at all non-load-slot edges, with no side effect.

Reset
REQ-025 SHALL, while i_rstn is low, asynchronously force phase=0, all shift registers=0, o_tx=0, o_clk_bits=0, o_ready=0, o_underflow=0, "started"=0, and PRBS state=7'h7F.
REQ-026 SHALL, on reset assertion mid-symbol, abandon the partial symbol; after release, the first load slot occurs at cycle DIV-1.

Configuration
REQ-027 SHALL compile in the PRBS test mode only when macro PHY_SERIALIZER_PRBS_EN is defined.
REQ-028 SHALL, with PHY_SERIALIZER_PRBS_EN defined and i_prbs_en high, load every data channel at each load slot with the next WORD_W bits of a PRBS7 sequence (x^7+x^6+1, advanced WORD_W steps per load, seeded 7'h7F); o_ready SHALL stay low and o_underflow SHALL NOT be set; the clock channel is unaffected.
REQ-029 SHALL, without PHY_SERIALIZER_PRBS_EN, retain the i_prbs_en port but ignore it, and infer no PRBS logic.

Verification (NUM_CH=3, WORD_W=10, OUT_BITS=2)
REQ-030 SHALL cover: release reset, i_valid=1, ch0=10'h3A5 accepted at the first ready -> ch0 o_tx over 5 cycles = 01,01,10,10,11.
REQ-031 SHALL cover: the same run -> o_clk_bits repeats 11,11,01,00,00, aligned with the ch0 symbol boundaries.
REQ-032 SHALL cover: i_valid held high for 20 cycles -> exactly 4 transfers, o_ready high at cycles 4,9,14,19 after reset release.
REQ-033 SHALL cover: after one transfer, i_valid=0 at the next load slot -> IDLE_WORD bits 00,01,01,01,11 on every channel, and o_underflow=1; pulse i_clr_underflow -> 0; set and clear on the same edge -> 1.
REQ-034 SHALL cover: i_rstn low at phase 2 of a symbol -> o_tx and o_clk_bits are 0 immediately (asynchronously); after release, the first o_ready occurs 4 cycles later.
REQ-035 SHALL cover: with PHY_SERIALIZER_PRBS_EN defined and i_prbs_en=1 -> o_tx matches the PRBS7 reference model on all 3 channels, o_ready stays 0, and o_underflow stays 0; without the macro, the same stimulus -> normal data path.
